// File: rtl/mac_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mac_ctrl_pkg : shared types for the mac row sequencer.      rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } mac_ctrl_state_t;

  // mac_n multiplier register plus accumulator register
  localparam int DRAIN_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/mac_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// mac_seq_ctrl_if : job control, operand stream and result port.  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mac_seq_ctrl_if #(
  parameter int N_LANES = 4,
  parameter int ABITS   = 10,
  parameter int ZBITS   = 22,
  parameter int LEN_W   = 8
) ();

  logic                     start;
  logic [LEN_W-1:0]         cfg_len;
  logic                     abort;
  logic                     busy;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_LANES*ABITS-1:0] in_a;
  logic [N_LANES*ABITS-1:0] in_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [N_LANES*ZBITS-1:0] res_z;

  modport master (
    output start, cfg_len, abort, in_valid, in_a, in_b, res_ready,
    input  busy, in_ready, res_valid, res_z
  );

  modport slave (
    input  start, cfg_len, abort, in_valid, in_a, in_b, res_ready,
    output busy, in_ready, res_valid, res_z
  );

endinterface

`default_nettype wire

// File: rtl/dff.sv
// ----------------------------------------------------------------------------
// dff : generic register, asynchronous active-high reset to zero.  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/mac_n.sv
// ----------------------------------------------------------------------------
// mac_n : registered signed multiply feeding a free-running accumulator. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_n #(
  parameter int aBits = 10,
  parameter int zBits = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [aBits-1:0] a,
  input  logic signed [aBits-1:0] b,
  input  logic                    clear,
  output logic        [zBits-1:0] z
);

  logic signed [2*aBits-1:0] mul_q, mul_d;
  logic        [zBits-1:0]   z_q, z_d, mul_ext;

  always_comb begin
    mul_d   = (2*aBits)'(a) * (2*aBits)'(b);
    mul_ext = {{(zBits-2*aBits){mul_q[2*aBits-1]}}, mul_q};
    // clear replaces the running sum with the product arriving this cycle
    z_d     = clear ? mul_ext : z_q + mul_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_q <= '0;
      z_q   <= '0;
    end else begin
      mul_q <= mul_d;
      z_q   <= z_d;
    end
  end

  assign z = z_q;

endmodule

`default_nettype wire

// File: rtl/mac_row.sv
// ----------------------------------------------------------------------------
// mac_row : mac_seq_ctrl driving N_LANES mac_n accumulators in lockstep. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_row #(
  parameter int N_LANES = 4,
  parameter int ABITS   = 10,
  parameter int ZBITS   = 22,
  parameter int LEN_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  mac_seq_ctrl_if.slave bus
);

  logic [N_LANES*ABITS-1:0] mac_a, mac_b;
  logic [N_LANES*ZBITS-1:0] mac_z;
  logic                     mac_clear;

  mac_seq_ctrl #(
    .N_LANES (N_LANES),
    .ABITS   (ABITS),
    .ZBITS   (ZBITS),
    .LEN_W   (LEN_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clear (mac_clear),
    .mac_z     (mac_z)
  );

  for (genvar i = 0; i < N_LANES; i++) begin : g_mac
    mac_n #(.aBits(ABITS), .zBits(ZBITS)) u_mac (
      .clk   (clk),
      .rst   (rst),
      .a     (mac_a[i*ABITS +: ABITS]),
      .b     (mac_b[i*ABITS +: ABITS]),
      .clear (mac_clear),
      .z     (mac_z[i*ZBITS +: ZBITS])
    );
  end

endmodule

`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
// ----------------------------------------------------------------------------
// mac_seq_ctrl : job sequencer, operand gating and result capture for mac_n. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int ABITS   = 10,
  parameter int ZBITS   = 22,
  parameter int LEN_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  mac_seq_ctrl_if.slave            bus,
  output logic [N_LANES*ABITS-1:0] mac_a,
  output logic [N_LANES*ABITS-1:0] mac_b,
  output logic                     mac_clear,
  input  logic [N_LANES*ZBITS-1:0] mac_z
);

  mac_ctrl_state_t          state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [N_LANES*ZBITS-1:0] res_z_q, res_z_d;
  logic                     clear_q, clear_d;
  logic                     beat, last_beat, drain_done;
  logic                     res_zero, res_capture;

  assign beat       = bus.in_valid & (state_q == RUN);
  assign last_beat  = beat & (cnt_q == len_q - LEN_W'(1));
  assign drain_done = (state_q == DRAIN) & (cnt_q == LEN_W'(DRAIN_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    clear_d     = 1'b0;
    res_zero    = 1'b0;
    res_capture = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.cfg_len != '0) begin
              len_d   = bus.cfg_len;
              cnt_d   = '0;
              state_d = RUN;
            end else begin
              res_zero = 1'b1;
              state_d  = HOLD;
            end
          end
        end
        RUN: begin
          if (beat) begin
            // lands with beat 0's product, dropping stale sum and bubble zeros
            clear_d = (cnt_q == '0);
            if (last_beat) begin
              cnt_d   = '0;
              state_d = DRAIN;
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            res_capture = 1'b1;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
        HOLD: begin
          if (bus.res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign mac_a[i*ABITS +: ABITS] = beat ? bus.in_a[i*ABITS +: ABITS] : '0;
    assign mac_b[i*ABITS +: ABITS] = beat ? bus.in_b[i*ABITS +: ABITS] : '0;
    assign res_z_d[i*ZBITS +: ZBITS] =
        res_zero    ? '0 :
        res_capture ? mac_z[i*ZBITS +: ZBITS] :
                      res_z_q[i*ZBITS +: ZBITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      res_z_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      res_z_q <= res_z_d;
    end
  end

  dff #(.WIDTH(1)) u_clear_reg (
    .clk (clk),
    .rst (rst),
    .d   (clear_d),
    .q   (clear_q)
  );

  assign mac_clear     = clear_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.in_ready  = (state_q == RUN);
  assign bus.res_valid = (state_q == HOLD);
  assign bus.res_z     = res_z_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mac_seq_ctrl : directed bench for mac_seq_ctrl with a row of mac_n lanes. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mac_seq_ctrl;

  localparam int N_LANES = 4;
  localparam int ABITS   = 10;
  localparam int ZBITS   = 22;
  localparam int LEN_W   = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [N_LANES*ABITS-1:0] mac_a, mac_b, exp_a;
  logic [N_LANES*ZBITS-1:0] mac_z;
  logic                     mac_clear;

  mac_seq_ctrl_if #(.N_LANES(N_LANES), .ABITS(ABITS), .ZBITS(ZBITS), .LEN_W(LEN_W)) bus ();

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .N_LANES (N_LANES),
    .ABITS   (ABITS),
    .ZBITS   (ZBITS),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clear (mac_clear),
    .mac_z     (mac_z)
  );

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    mac_n #(.aBits(ABITS), .zBits(ZBITS)) u_mac (
      .clk   (clk),
      .rst   (rst),
      .a     (mac_a[i*ABITS +: ABITS]),
      .b     (mac_b[i*ABITS +: ABITS]),
      .clear (mac_clear),
      .z     (mac_z[i*ZBITS +: ZBITS])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lane i gets a*(i+1) when scale is set, so every lane carries a distinct sum
  task automatic set_ops(input int a, input int b, input bit scale);
    for (int i = 0; i < N_LANES; i++) begin
      bus.in_a[i*ABITS +: ABITS] = ABITS'(scale ? a * (i + 1) : a);
      bus.in_b[i*ABITS +: ABITS] = ABITS'(b);
      exp_a[i*ABITS +: ABITS]    = ABITS'(scale ? a * (i + 1) : a);
    end
  endtask

  task automatic send_beat(input int a, input int b, input bit scale);
    set_ops(a, b, scale);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic release_result();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ops(3, 3, 1'b1);
    bus.in_valid = 1'b1;
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 || mac_clear !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got in_ready=%b res_valid=%b mac_clear=%b exp=0,0,0",
               bus.in_ready, bus.res_valid, mac_clear);
    end
    checks++;
    if (mac_a !== '0 || mac_b !== '0) begin
      failures++; $display("FAIL reset_mac_ops got a=%h b=%h exp=0", mac_a, mac_b);
    end
    checks++;
    if (bus.res_z !== '0) begin
      failures++; $display("FAIL reset_res_z got=%h exp=0", bus.res_z);
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_single_beat();
    logic [ZBITS-1:0] e;
    bus.start = 1'b1; bus.cfg_len = 8'd1;
    step();                                   // cycle 1: RUN
    bus.start = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL single_in_ready got=%b exp=1", bus.in_ready);
    end
    set_ops(3, -5, 1'b1);
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (mac_a !== exp_a) begin
      failures++; $display("FAIL single_mac_a_on_beat got=%h exp=%h", mac_a, exp_a);
    end
    step();                                   // cycle 2: DRAIN, clear
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (mac_clear !== 1'b1) begin
      failures++; $display("FAIL single_clear got=%b exp=1", mac_clear);
    end
    checks++;
    if (mac_a !== '0 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL single_drain_gate got mac_a=%h in_ready=%b exp=0,0", mac_a, bus.in_ready);
    end
    step();                                   // cycle 3
    checks++;
    if (bus.res_valid !== 1'b0 || mac_clear !== 1'b0) begin
      failures++; $display("FAIL single_early got res_valid=%b clear=%b exp=0,0", bus.res_valid, mac_clear);
    end
    step();                                   // cycle 4: HOLD
    checks++;
    if (bus.res_valid !== 1'b1) begin
      failures++; $display("FAIL single_res_valid got=%b exp=1", bus.res_valid);
    end
    for (int i = 0; i < N_LANES; i++) begin
      e = ZBITS'(-15 * (i + 1));
      checks++;
      if (bus.res_z[i*ZBITS +: ZBITS] !== e) begin
        failures++; $display("FAIL single_res_z lane%0d got=%h exp=%h", i, bus.res_z[i*ZBITS +: ZBITS], e);
      end
    end
    release_result();
    checks++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL single_release got busy=%b res_valid=%b exp=0,0", bus.busy, bus.res_valid);
    end
  endtask

  task automatic test_bubbles();
    logic [ZBITS-1:0] e;
    bus.start = 1'b1; bus.cfg_len = 8'd4;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_beat(2*k + 1, 2*k + 2, 1'b1);
      if (k < 3) begin
        for (int g = 0; g < 3; g++) begin
          set_ops(9, 9, 1'b1);
          #1;
          checks++;
          if (mac_a !== '0) begin
            failures++; $display("FAIL bubble_mac_a k%0d g%0d got=%h exp=0", k, g, mac_a);
          end
          step();
        end
      end
    end
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL bubble_early got=%b exp=0", bus.res_valid);
    end
    step();
    step();
    checks++;
    if (bus.res_valid !== 1'b1) begin
      failures++; $display("FAIL bubble_res_valid got=%b exp=1", bus.res_valid);
    end
    for (int i = 0; i < N_LANES; i++) begin
      e = ZBITS'(100 * (i + 1));
      checks++;
      if (bus.res_z[i*ZBITS +: ZBITS] !== e) begin
        failures++; $display("FAIL bubble_res_z lane%0d got=%0d exp=%0d", i, bus.res_z[i*ZBITS +: ZBITS], e);
      end
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [ZBITS-1:0] e;
    bus.start = 1'b1; bus.cfg_len = 8'd4;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) send_beat(2*k + 1, 2*k + 2, 1'b1);
    step();
    step();
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_z[ZBITS-1:0] !== 22'd100) begin
      failures++; $display("FAIL b2b_job_a got valid=%b z=%0d exp=1,100", bus.res_valid, bus.res_z[ZBITS-1:0]);
    end
    release_result();
    bus.start = 1'b1; bus.cfg_len = 8'd2;
    step();
    bus.start = 1'b0;
    send_beat(2, 2, 1'b1);
    send_beat(1, 1, 1'b1);
    step();
    step();
    checks++;
    if (bus.res_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_res_valid got=%b exp=1", bus.res_valid);
    end
    for (int i = 0; i < N_LANES; i++) begin
      e = ZBITS'(5 * (i + 1));
      checks++;
      if (bus.res_z[i*ZBITS +: ZBITS] !== e) begin
        failures++; $display("FAIL b2b_res_z lane%0d got=%0d exp=%0d", i, bus.res_z[i*ZBITS +: ZBITS], e);
      end
    end
    release_result();
  endtask

  task automatic test_backpressure();
    bus.start = 1'b1; bus.cfg_len = 8'd1;
    step();
    bus.start = 1'b0;
    send_beat(1, 1, 1'b1);
    step();
    step();
    bus.start = 1'b1; bus.cfg_len = 8'd5;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.res_valid !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold c%0d got valid=%b busy=%b in_ready=%b exp=1,1,0",
                 c, bus.res_valid, bus.busy, bus.in_ready);
      end
      checks++;
      if (bus.res_z[ZBITS-1:0] !== 22'd1 || bus.res_z[3*ZBITS +: ZBITS] !== 22'd4) begin
        failures++; $display("FAIL bp_stable c%0d got=%h exp lane0=1 lane3=4", c, bus.res_z);
      end
      step();
    end
    bus.start = 1'b0;
    release_result();
    checks++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release got busy=%b valid=%b exp=0,0", bus.busy, bus.res_valid);
    end
  endtask

  task automatic test_abort();
    logic [ZBITS-1:0] e;
    bus.start = 1'b1; bus.cfg_len = 8'd3; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL abort_over_start got busy=%b exp=0", bus.busy);
    end
    bus.start = 1'b1; bus.cfg_len = 8'd2;
    step();
    bus.start = 1'b0;
    set_ops(9, 9, 1'b1);
    bus.in_valid = 1'b1; bus.abort = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || mac_clear !== 1'b0) begin
      failures++; $display("FAIL abort_first_beat got busy=%b clear=%b exp=0,0", bus.busy, mac_clear);
    end
    bus.start = 1'b1; bus.cfg_len = 8'd3;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) send_beat(1, 1, 1'b1);
    step();                                   // second DRAIN cycle
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL abort_drain got busy=%b valid=%b exp=0,0", bus.busy, bus.res_valid);
    end
    step();
    step();
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL abort_no_result got=%b exp=0", bus.res_valid);
    end
    bus.start = 1'b1; bus.cfg_len = 8'd1;
    step();
    bus.start = 1'b0;
    send_beat(4, 4, 1'b1);
    step();
    step();
    checks++;
    if (bus.res_valid !== 1'b1) begin
      failures++; $display("FAIL abort_next_valid got=%b exp=1", bus.res_valid);
    end
    for (int i = 0; i < N_LANES; i++) begin
      e = ZBITS'(16 * (i + 1));
      checks++;
      if (bus.res_z[i*ZBITS +: ZBITS] !== e) begin
        failures++; $display("FAIL abort_next_res_z lane%0d got=%0d exp=%0d", i, bus.res_z[i*ZBITS +: ZBITS], e);
      end
    end
    release_result();
  endtask

  task automatic test_len_zero();
    bus.start = 1'b1; bus.cfg_len = 8'd0;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b1 || mac_clear !== 1'b0) begin
      failures++; $display("FAIL len0_valid got valid=%b clear=%b exp=1,0", bus.res_valid, mac_clear);
    end
    checks++;
    if (bus.res_z !== '0) begin
      failures++; $display("FAIL len0_res_z got=%h exp=0", bus.res_z);
    end
    release_result();
  endtask

  task automatic test_len_max();
    bus.start = 1'b1; bus.cfg_len = 8'd255;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 255; k++) send_beat(-512, -512, 1'b0);
    step();
    step();
    checks++;
    if (bus.res_valid !== 1'b1) begin
      failures++; $display("FAIL max_res_valid got=%b exp=1", bus.res_valid);
    end
    // 255 * 2**18 = 2**26 - 2**18, which is 2**22 - 2**18 modulo 2**22
    for (int i = 0; i < N_LANES; i++) begin
      checks++;
      if (bus.res_z[i*ZBITS +: ZBITS] !== 22'd3932160) begin
        failures++; $display("FAIL max_res_z lane%0d got=%0d exp=3932160", i, bus.res_z[i*ZBITS +: ZBITS]);
      end
    end
    release_result();
  endtask

  task automatic test_async_reset();
    bus.start = 1'b1; bus.cfg_len = 8'd3;
    step();
    bus.start = 1'b0;
    set_ops(5, 5, 1'b1);
    bus.in_valid = 1'b1;
    step();                                   // RUN, clear high, second beat on the bus
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_flags got busy=%b in_ready=%b valid=%b exp=0,0,0",
               bus.busy, bus.in_ready, bus.res_valid);
    end
    checks++;
    if (mac_a !== '0 || mac_b !== '0 || mac_clear !== 1'b0) begin
      failures++; $display("FAIL arst_mac got a=%h b=%h clear=%b exp=0", mac_a, mac_b, mac_clear);
    end
    checks++;
    if (bus.res_z !== '0) begin
      failures++; $display("FAIL arst_res_z got=%h exp=0", bus.res_z);
    end
    bus.in_valid = 1'b0;
    #3 rst = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL arst_after got busy=%b exp=0", bus.busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.cfg_len   = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    exp_a         = '0;
    test_reset();
    test_single_beat();
    test_bubbles();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_len_zero();
    test_len_max();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
